ternary_tile_sequencer: RTL and testbench



---
 rtl/ternary_tile_sequencer_if.sv | 22 ++
 rtl/ternary_tile_sequencer.sv | 119 +++++++++++
 tb/tb_ternary_tile_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ternary_tile_sequencer_if.sv
// Host-side streaming bundle for ternary_tile_sequencer: weight/activation beats in, result bytes out.
// Both directions use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface ternary_tile_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] weights_in;
    logic [7:0] act_in;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    modport master (
        output in_valid, weights_in, act_in, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, weights_in, act_in, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/ternary_tile_sequencer.sv
// Sequences one tile on the 4-row ternary systolic array: clear, feed K beats, copy, capture 4 bytes, emit.
// Optional macro SEQ_RELU_EN: captured bytes with bit 7 set are stored as zero.
module ternary_tile_sequencer #(
    parameter int H  = 4,
    parameter int KW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [KW-1:0]        cfg_k,
    ternary_tile_sequencer_if.slave host,
    output logic [H-1:0]         arr_left_zero,
    output logic [H-1:0]         arr_left_sign,
    output logic [7:0]           arr_top,
    output logic                 arr_reset_acc,
    output logic                 arr_copy_out,
    output logic                 arr_restart_out,
    input  logic [7:0]           arr_out,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_EMIT  = 3'd5;

    logic [2:0]    state;
    logic [KW-1:0] k_reg;
    logic [KW-1:0] beat_cnt;
    logic [1:0]    idx;
    logic [7:0]    rbuf [H];
    logic [7:0]    capture;
    logic          accept;
    logic          emit_hs;
    logic [1:0]    code;

`ifdef SEQ_RELU_EN
    assign capture = arr_out[7] ? 8'h00 : arr_out;
`else
    assign capture = arr_out;
`endif

    assign accept          = (state == S_FEED) && host.in_valid;
    assign emit_hs         = (state == S_EMIT) && host.out_ready;
    assign host.in_ready   = (state == S_FEED);
    assign host.out_valid  = (state == S_EMIT);
    assign host.out_data   = (state == S_EMIT) ? rbuf[idx] : 8'h00;
    assign host.out_last   = (state == S_EMIT) && (idx == 2'd3);
    assign arr_reset_acc   = (state == S_CLEAR);
    assign arr_copy_out    = (state == S_DRAIN);
    assign arr_restart_out = (state == S_DRAIN);
    assign busy            = (state != S_IDLE);
    assign done            = emit_hs && (idx == 2'd3);
    assign dbg_state       = state;

    // Without an accepted beat the array sees zero weights, so its cycle adds nothing.
    always_comb begin
        arr_left_zero = '1;
        arr_left_sign = '0;
        arr_top       = 8'h00;
        code          = 2'b00;
        if (accept) begin
            arr_top = host.act_in;
            for (int i = 0; i < H; i++) begin
                code             = host.weights_in[2*(H-1-i) +: 2];
                arr_left_zero[i] = ~|code;
                arr_left_sign[i] = code[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            k_reg    <= '0;
            beat_cnt <= '0;
            idx      <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_reg    <= cfg_k;
                        beat_cnt <= '0;
                        state    <= S_CLEAR;
                    end
                end
                S_CLEAR: state <= (k_reg == '0) ? S_DRAIN : S_FEED;
                S_FEED: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt + 1'b1 == k_reg) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    idx   <= 2'd0;
                    state <= S_READ;
                end
                // idx walks the queue while reading, then the buffer while emitting.
                S_READ: begin
                    rbuf[idx] <= capture;
                    idx       <= idx + 2'd1;
                    if (idx == 2'd3) state <= S_EMIT;
                end
                S_EMIT: begin
                    if (host.out_ready) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_tile_sequencer.sv
// Bench for ternary_tile_sequencer with a behavioural 4-row array model and an output scoreboard.
module tb_ternary_tile_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] cfg_k;
    logic [3:0] arr_left_zero, arr_left_sign;
    logic [7:0] arr_top, arr_out;
    logic       arr_reset_acc, arr_copy_out, arr_restart_out;
    logic       busy, done;
    logic [2:0] dbg_state;

    ternary_tile_sequencer_if host ();

    ternary_tile_sequencer #(.H(4), .KW(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .cfg_k           (cfg_k),
        .host            (host.slave),
        .arr_left_zero   (arr_left_zero),
        .arr_left_sign   (arr_left_sign),
        .arr_top         (arr_top),
        .arr_reset_acc   (arr_reset_acc),
        .arr_copy_out    (arr_copy_out),
        .arr_restart_out (arr_restart_out),
        .arr_out         (arr_out),
        .busy            (busy),
        .done            (done),
        .dbg_state       (dbg_state)
    );

    // clock / global watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // array model: registered inputs, summed the following cycle, copy captures the pending sum
    logic [3:0]        m_zero = 4'hF, m_sign = 4'h0;
    logic [7:0]        m_top = 8'h00;
    logic signed [16:0] m_acc [4];
    logic signed [16:0] m_nxt [4];
    logic [7:0]        m_q [4];
    logic [1:0]        m_idx = 2'd0;

    initial for (int i = 0; i < 4; i++) begin m_acc[i] = '0; m_q[i] = 8'h00; end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            m_nxt[i] = m_acc[i];
            if (!m_zero[i]) m_nxt[i] = m_sign[i] ? m_acc[i] - {{9{m_top[7]}}, m_top}
                                                 : m_acc[i] + {{9{m_top[7]}}, m_top};
        end
    end

    always @(posedge clk) begin
        m_zero <= arr_left_zero;
        m_sign <= arr_left_sign;
        m_top  <= arr_top;
        for (int i = 0; i < 4; i++) begin
            m_acc[i] <= arr_reset_acc ? 17'sd0 : m_nxt[i];
            if (arr_copy_out) m_q[i] <= m_nxt[i][7:0];
        end
        m_idx <= arr_restart_out ? 2'd0 : m_idx + 2'd1;
    end

    assign arr_out = m_q[m_idx];

    // scoreboard state
    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q [$];
    int cyc = 0;
    int beats_seen = 0;
    int ov_seen = 0;
    bit in_ready_seen = 0;
    bit tog_mode = 0;
    logic [7:0] tw [256];
    logic [7:0] ta [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // output monitor: pops and compares every accepted result byte
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (host.in_valid && host.in_ready) beats_seen++;
            if (host.in_ready) in_ready_seen = 1;
            if (host.out_valid) ov_seen++;
            if (host.out_valid && host.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {24'h0, host.out_data}, {24'h0, e[7:0]});
                    check("out_last", {31'h0, host.out_last}, {31'h0, e[8]});
                    check("done", {31'h0, done}, {31'h0, e[8]});
                end
            end
        end
    end

    // out_ready driver: steady high or toggling every cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            host.out_ready = tog_mode ? ~host.out_ready : 1'b1;
        end
    end

    // expected bytes straight from the ternary arithmetic of the loaded beats
    task automatic push_expected(input int k);
        int sum [4];
        logic [1:0] c;
        logic [7:0] b;
        for (int r = 0; r < 4; r++) sum[r] = 0;
        for (int j = 0; j < k; j++)
            for (int r = 0; r < 4; r++) begin
                c = tw[j][2*(3-r) +: 2];
                if (c == 2'b01) sum[r] += $signed(ta[j]);
                else if (c != 2'b00) sum[r] -= $signed(ta[j]);
            end
        for (int r = 0; r < 4; r++) begin
            b = sum[r][7:0];
`ifdef SEQ_RELU_EN
            if (b[7]) b = 8'h00;
`endif
            exp_q.push_back({(r == 3), b});
        end
    endtask

    // driver: called at posedge+1; returns at posedge+1 of the cycle after acceptance
    task automatic send_beat(input logic [7:0] w, input logic [7:0] a, input int gap);
        int t;
        host.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        host.in_valid   = 1'b1;
        host.weights_in = w;
        host.act_in     = a;
        t = 0;
        while (t < 200) begin
            @(negedge clk);
            if (host.in_ready) break;
            t++;
        end
        if (t >= 200) check("beat_timeout", 1, 0);
        @(posedge clk);
        #1;
        host.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int at);
        int t;
        t = 0;
        at = -1;
        while (t < 3000) begin
            @(negedge clk);
            if (done) begin at = cyc; break; end
            t++;
        end
        if (at < 0) check("done_timeout", 1, 0);
    endtask

    task automatic run_tile(input int k, input int gap, input bit poke, input bit timed);
        int c0, c1;
        push_expected(k);
        beats_seen = 0;
        in_ready_seen = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_k = 8'(k);
        c0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_k = 8'($urandom_range(0, 255));
        for (int j = 0; j < k; j++) begin
            if (poke && j == k / 2) start = 1'b1;
            send_beat(tw[j], ta[j], gap);
            start = 1'b0;
        end
        wait_done(c1);
        check("beat_count", beats_seen, k);
        if (k == 0) check("k0_in_ready", {31'h0, in_ready_seen}, 0);
        if (timed) check("tile_latency", c1 - c0, k + 10);
        @(negedge clk);
        check("busy_after_done", {31'h0, busy}, 0);
    endtask

    initial begin
        int t;
        reset = 1'b1;
        start = 1'b0;
        cfg_k = 8'h00;
        host.in_valid = 1'b0;
        host.weights_in = 8'h00;
        host.act_in = 8'h00;
        host.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'h0, host.in_ready}, 0);
        check("rst_out_valid", {31'h0, host.out_valid}, 0);
        check("rst_out_last", {31'h0, host.out_last}, 0);
        check("rst_out_data", {24'h0, host.out_data}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_done", {31'h0, done}, 0);
        check("rst_reset_acc", {31'h0, arr_reset_acc}, 0);
        check("rst_copy_out", {31'h0, arr_copy_out}, 0);
        check("rst_restart_out", {31'h0, arr_restart_out}, 0);
        check("rst_top", {24'h0, arr_top}, 0);
        check("rst_sign", {28'h0, arr_left_sign}, 0);
        check("rst_zero", {28'h0, arr_left_zero}, 32'hF);

        // K=2 reference tile, then the same with input gaps and toggling out_ready
        tw[0] = 8'hC9; ta[0] = 8'd5;
        tw[1] = 8'h55; ta[1] = 8'd3;
        tog_mode = 0;
        run_tile(2, 0, 0, 1);
        tog_mode = 1;
        run_tile(2, 3, 0, 0);
        tog_mode = 0;

        // K=0: clear, drain, four zero bytes
        run_tile(0, 0, 0, 0);

        // random short tiles
        for (int n = 0; n < 3; n++) begin
            int k;
            k = $urandom_range(1, 6);
            for (int j = 0; j < k; j++) begin
                tw[j] = 8'($urandom_range(0, 255));
                ta[j] = 8'($urandom_range(0, 255));
            end
            tog_mode = n[0];
            run_tile(k, $urandom_range(0, 2), 0, 0);
        end
        tog_mode = 0;

        // K=255 all +1 weights, act 1, with a stray start mid-feed
        for (int j = 0; j < 255; j++) begin tw[j] = 8'h55; ta[j] = 8'd1; end
        run_tile(255, 0, 1, 1);

        // reset asserted during READ: no output, back to IDLE
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_k = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_beat(8'h55, 8'd7, 0);
        t = 0;
        while (t < 50) begin
            @(negedge clk);
            if (dbg_state == 3'd4) break;
            t++;
        end
        check("reach_read", {29'h0, dbg_state}, 32'd4);
        ov_seen = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_read_busy", {31'h0, busy}, 0);
        check("rst_read_state", {29'h0, dbg_state}, 0);
        repeat (10) @(negedge clk);
        check("rst_read_no_out", ov_seen, 0);

        // recovery tile after the mid-tile reset
        tw[0] = 8'hC9; ta[0] = 8'd5;
        tw[1] = 8'h55; ta[1] = 8'd3;
        run_tile(2, 1, 0, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
